fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the instruction memory: owns the program counter, drives the memory's word address and registers the returned instruction word into a fetch register for the decoder. Handles sequential advance (PC+4), redirects from branch/jump resolution, downstream stalls and fetch faults (misaligned target, address beyond instruction-memory range). It also supplies `instr_pc` and `instr_pc_plus4` for link and branch arithmetic downstream.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, addresses instruction
// memory and registers the returned word for the decoder. Handles sequential
// advance, redirects, downstream stalls and sticky fetch faults.
// Optional macro FETCH_PERF_EN adds saturating fetch/bubble counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] A,
  input  logic [31:0] RD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;

  logic load;
  logic in_range;
  logic misaligned;
  logic fetch_evt;

  assign load       = !stall || !instr_valid_q;
  assign in_range   = {1'b0, pc_q} < IMEM_LIMIT;
  assign misaligned = redirect_pc[1:0] != 2'b00;

  // State register: RUN after reset, HALT once a fault is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state: any fault while running parks the stage in HALT until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN) begin
      if (redirect_valid && misaligned)          state_d = HALT;
      else if (!redirect_valid && load && !in_range) state_d = HALT;
    end
  end

  // Datapath next values in priority order: redirect, range fault, fetch, hold.
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    fetch_evt     = 1'b0;
    if (state_q == RUN) begin
      if (redirect_valid) begin
        instr_valid_d = 1'b0;
        instr_d       = NOP;
        if (misaligned) fault_d = 1'b1;
        else            pc_d    = redirect_pc;
      end else if (load) begin
        if (!in_range) begin
          fault_d       = 1'b1;
          instr_valid_d = 1'b0;
          instr_d       = NOP;
        end else begin
          instr_d       = RD;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_evt     = 1'b1;
        end
      end
    end
  end

  // Datapath registers with asynchronous reset to the boot values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  // Outputs are straight from the registers; link address is derived here.
  always_comb begin
    A              = pc_q;
    instr          = instr_q;
    instr_pc       = instr_pc_q;
    instr_pc_plus4 = instr_pc_q + 32'd4;
    instr_valid    = instr_valid_q;
    fault          = fault_q;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  // Saturating counters; they only move on edges taken while running.
  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (fetch_evt && fetch_count_q != 32'hFFFF_FFFF)
      fetch_count_d = fetch_count_q + 32'd1;
    if (state_q == RUN && !instr_valid_d && bubble_count_q != 32'hFFFF_FFFF)
      bubble_count_d = bubble_count_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q  <= 32'd0;
      bubble_count_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational instruction-memory
// model and hand-computed expected values.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] RD;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  logic [31:0] mem [0:1023];
  int checks;
  int errors;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(1024)) dut (
    .clk            (clk),
    .reset          (reset),
    .A              (A),
    .RD             (RD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .fault          (fault)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`endif
  );

  // Instruction memory answers combinationally from A; out of range reads 0.
  assign RD = (A[31:12] == 20'd0) ? mem[A[11:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic st);
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[0]    = 32'h00200293;
    mem[1]    = 32'h04000313;
    mem[2]    = 32'h00532423;
    mem[3]    = 32'h00832383;
    mem[1023] = 32'hDEAD_BEEF;

    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #12;
    checkOutput("rst_A", A, 32'h0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instr, 32'h13);
    checkOutput("rst_ipc", instr_pc, 32'h0);
    checkOutput("rst_ipc4", instr_pc_plus4, 32'h4);
    checkOutput("rst_fault", {31'd0, fault}, 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("rst_fcnt", fetch_count, 32'd0);
    checkOutput("rst_bcnt", bubble_count, 32'd0);
`endif

    // Sequential fetch of the first two words
    @(posedge clk); #1;
    reset = 1'b1;
    clockEdge();
    checkOutput("seq0_instr", instr, 32'h00200293);
    checkOutput("seq0_ipc", instr_pc, 32'h0);
    checkOutput("seq0_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("seq0_A", A, 32'h4);
    clockEdge();
    checkOutput("seq1_instr", instr, 32'h04000313);
    checkOutput("seq1_ipc", instr_pc, 32'h4);
    checkOutput("seq1_ipc4", instr_pc_plus4, 32'h8);

    // Stall holds instruction and address for three cycles
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      clockEdge();
      checkOutput("stall_instr", instr, 32'h04000313);
      checkOutput("stall_A", A, 32'h8);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    clockEdge();
    checkOutput("seq2_instr", instr, 32'h00532423);
    checkOutput("seq2_ipc", instr_pc, 32'h8);
    clockEdge();
    checkOutput("seq3_instr", instr, 32'h00832383);
    checkOutput("seq3_ipc", instr_pc, 32'hC);
    checkOutput("seq3_fault", {31'd0, fault}, 32'd0);
    checkOutput("seq3_A", A, 32'h10);

    // Redirect wins over stall and produces one bubble
    applyStimulus(1'b1, 32'h0, 1'b1);
    clockEdge();
    checkOutput("redir_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("redir_instr", instr, 32'h13);
    checkOutput("redir_A", A, 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("redir_bcnt", bubble_count, 32'd1);
`endif
    // Bubble is refilled even though stall stays high
    applyStimulus(1'b0, 32'h0, 1'b1);
    clockEdge();
    checkOutput("refill_instr", instr, 32'h00200293);
    checkOutput("refill_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("refill_A", A, 32'h4);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fcnt", fetch_count, 32'd5);
    checkOutput("perf_bcnt", bubble_count, 32'd1);
`endif
    clockEdge();
    checkOutput("hold_instr", instr, 32'h00200293);
    checkOutput("hold_A", A, 32'h4);

    // Misaligned redirect faults and halts
    applyStimulus(1'b1, 32'h6, 1'b0);
    clockEdge();
    checkOutput("mis_fault", {31'd0, fault}, 32'd1);
    checkOutput("mis_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("mis_A", A, 32'h4);
    checkOutput("mis_instr", instr, 32'h13);
    applyStimulus(1'b1, 32'h100, 1'b0);
    clockEdge();
    applyStimulus(1'b0, 32'h0, 1'b1);
    clockEdge();
    applyStimulus(1'b0, 32'h0, 1'b0);
    clockEdge();
    checkOutput("halt_A", A, 32'h4);
    checkOutput("halt_fault", {31'd0, fault}, 32'd1);
    checkOutput("halt_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("halt_ipc", instr_pc, 32'h0);

    // Asynchronous reset clears the halt immediately
    #2;
    reset = 1'b0;
    #1;
    checkOutput("areset_A", A, 32'h0);
    checkOutput("areset_fault", {31'd0, fault}, 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("areset_fcnt", fetch_count, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;

    // Redirect to the last word, then run off the end of memory
    applyStimulus(1'b1, 32'hFFC, 1'b0);
    clockEdge();
    checkOutput("end_redir_A", A, 32'hFFC);
    checkOutput("end_redir_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    clockEdge();
    checkOutput("end_instr", instr, 32'hDEAD_BEEF);
    checkOutput("end_ipc", instr_pc, 32'hFFC);
    checkOutput("end_ipc4", instr_pc_plus4, 32'h1000);
    checkOutput("end_fault0", {31'd0, fault}, 32'd0);
    clockEdge();
    checkOutput("range_fault", {31'd0, fault}, 32'd1);
    checkOutput("range_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("range_A", A, 32'h1000);
    checkOutput("range_instr", instr, 32'h13);
    checkOutput("range_ipc", instr_pc, 32'hFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
